// File: rtl/wallace_tree_multiplier_if.sv
// Operand/product bundle for the Wallace-tree multiplier.
// The master side presents operand pairs; the slave side returns registered products.
interface wallace_tree_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   C;

    modport master (
        output in_valid,
        output A,
        output B,
        input  out_valid,
        input  C
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        output out_valid,
        output C
    );
endinterface

// File: rtl/wallace_tree_multiplier.sv
// Unsigned WIDTHxWIDTH multiplier with a 1-cycle registered result.
// Partial products are reduced by a Wallace tree of 3:2 carry-save layers.
// A single carry-propagate add then produces the product in front of the output register.

// One Wallace reduction layer: rows are taken three at a time and compressed to a
// sum row and a carry row. Rows left over from the grouping pass straight through.
// Where one input bit is known zero, the full adder collapses to a half adder in synthesis.
module wallace_csa_layer #(
    parameter int N_IN = 3,
    parameter int P    = 64
) (
    input  logic [P-1:0] rows_in  [N_IN],
    output logic [P-1:0] rows_out [2*(N_IN/3) + N_IN%3]
);
    localparam int N_GRP  = N_IN / 3;
    localparam int N_LEFT = N_IN % 3;

    for (genvar g = 0; g < N_GRP; g++) begin : g_csa
        // Carry weight is one column higher, so the majority term shifts left by one.
        // A carry out of the top column is dropped; it cannot occur for a valid product.
        assign rows_out[2*g]   = rows_in[3*g] ^ rows_in[3*g+1] ^ rows_in[3*g+2];
        assign rows_out[2*g+1] = ((rows_in[3*g]   & rows_in[3*g+1]) |
                                  (rows_in[3*g]   & rows_in[3*g+2]) |
                                  (rows_in[3*g+1] & rows_in[3*g+2])) << 1;
    end

    for (genvar r = 0; r < N_LEFT; r++) begin : g_pass
        assign rows_out[2*N_GRP + r] = rows_in[3*N_GRP + r];
    end
endmodule

module wallace_tree_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wallace_tree_multiplier_if.slave bus
);
    localparam int P = 2 * WIDTH;

    function automatic int rows_after(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    // Row counts per layer: 32 -> 22 -> 15 -> 10 -> 7 -> 5 -> 4 -> 3 -> 2.
    // Eight layers reach two rows for any WIDTH up to 42.
    localparam int N0 = WIDTH;
    localparam int N1 = rows_after(N0);
    localparam int N2 = rows_after(N1);
    localparam int N3 = rows_after(N2);
    localparam int N4 = rows_after(N3);
    localparam int N5 = rows_after(N4);
    localparam int N6 = rows_after(N5);
    localparam int N7 = rows_after(N6);
    localparam int N8 = rows_after(N7);

    logic [P-1:0] pp [N0];
    logic [P-1:0] r1 [N1];
    logic [P-1:0] r2 [N2];
    logic [P-1:0] r3 [N3];
    logic [P-1:0] r4 [N4];
    logic [P-1:0] r5 [N5];
    logic [P-1:0] r6 [N6];
    logic [P-1:0] r7 [N7];
    logic [P-1:0] r8 [N8];

    logic [P-1:0] product;
    logic [P-1:0] c_d;
    logic [P-1:0] c_q;
    logic         out_valid_d;
    logic         out_valid_q;

    // Partial-product row i is A gated by B[i], placed at weight 2^i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign pp[i] = {{WIDTH{1'b0}}, (bus.A & {WIDTH{bus.B[i]}})} << i;
    end

    wallace_csa_layer #(.N_IN(N0), .P(P)) u_layer1 (.rows_in(pp), .rows_out(r1));
    wallace_csa_layer #(.N_IN(N1), .P(P)) u_layer2 (.rows_in(r1), .rows_out(r2));
    wallace_csa_layer #(.N_IN(N2), .P(P)) u_layer3 (.rows_in(r2), .rows_out(r3));
    wallace_csa_layer #(.N_IN(N3), .P(P)) u_layer4 (.rows_in(r3), .rows_out(r4));
    wallace_csa_layer #(.N_IN(N4), .P(P)) u_layer5 (.rows_in(r4), .rows_out(r5));
    wallace_csa_layer #(.N_IN(N5), .P(P)) u_layer6 (.rows_in(r5), .rows_out(r6));
    wallace_csa_layer #(.N_IN(N6), .P(P)) u_layer7 (.rows_in(r6), .rows_out(r7));
    wallace_csa_layer #(.N_IN(N7), .P(P)) u_layer8 (.rows_in(r7), .rows_out(r8));

    // Final carry-propagate add of the last two rows; the carry out of the top bit is dropped.
    assign product = r8[0] + r8[1];

    // Next-state: load a new product only on valid input, otherwise hold the last one.
    always_comb begin
        c_d         = c_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            c_d = product;
        end
    end

    // Output register; reset clears both product and valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.C         = c_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_wallace_tree_multiplier.sv
// Bench for wallace_tree_multiplier: directed vector table, back-to-back stream,
// asynchronous reset corners and a randomized run against a plain-arithmetic model.
module tb_wallace_tree_multiplier;
    logic clk;
    logic rst_n;

    wallace_tree_multiplier_if #(.WIDTH(32)) bus ();

    wallace_tree_multiplier #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: last product accepted and the valid expected after the edge.
    logic [63:0] exp_c;
    logic        exp_v;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] c;
        logic        ov;
    } vec_t;

    vec_t tbl [10];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    // Present one operand pair on the falling edge, then observe just after the rising edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        @(posedge clk);
        #1;
        if (v) exp_c = 64'(a) * 64'(b);
        exp_v = v;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rv;

        tbl[0] = '{1'b1, 32'h80100282, 32'h00000060, 64'h000000300600F0C0, 1'b1};
        tbl[1] = '{1'b1, 32'hAAAAAAAA, 32'h55555555, 64'h38E38E3871C71C72, 1'b1};
        tbl[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1};
        tbl[3] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, 1'b1};
        tbl[4] = '{1'b1, 32'h00000001, 32'h12345678, 64'h0000000012345678, 1'b1};
        tbl[5] = '{1'b0, 32'hDEADBEEF, 32'h00000002, 64'h0000000012345678, 1'b0};
        tbl[6] = '{1'b1, 32'h12345678, 32'h00000000, 64'h0000000000000000, 1'b1};
        tbl[7] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF, 1'b1};
        tbl[8] = '{1'b1, 32'h00010000, 32'h00010000, 64'h0000000100000000, 1'b1};
        tbl[9] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b1};

        // Reset held with clock running and valid operands present: outputs stay cleared.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = 32'hFFFFFFFF;
        bus.B        = 32'hFFFFFFFF;
        exp_c        = '0;
        exp_v        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_c", bus.C, 64'h0);
        check1("reset_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // First edge after release with no valid input: outputs remain zero.
        step(1'b0, 32'h0, 32'h0);
        check64("post_reset_c", bus.C, 64'h0);
        check1("post_reset_valid", bus.out_valid, 1'b0);

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].b);
            check64($sformatf("vec%0d_c", i), bus.C, tbl[i].c);
            check1($sformatf("vec%0d_valid", i), bus.out_valid, tbl[i].ov);
        end

        // Seven back-to-back valid operand pairs.
        begin
            logic [31:0] sa [7];
            logic [31:0] sb [7];
            sa = '{32'h8648439B, 32'h00000003, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h0000FFFF, 32'hC0FFEE00, 32'h00000000};
            sb = '{32'h3C652C61, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 32'hFFFF0000, 32'h12345678, 32'h87654321};
            for (int i = 0; i < 7; i++) begin
                step(1'b1, sa[i], sb[i]);
                check64($sformatf("b2b%0d_c", i), bus.C, exp_c);
                check1($sformatf("b2b%0d_valid", i), bus.out_valid, 1'b1);
            end
        end

        // Asynchronous reset while a nonzero valid product is showing.
        step(1'b1, 32'h8648439B, 32'h3C652C61);
        check64("pre_async_c", bus.C, 64'h8648439B * 64'h3C652C61);
        check1("pre_async_valid", bus.out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check64("async_rst_c", bus.C, 64'h0);
        check1("async_rst_valid", bus.out_valid, 1'b0);
        exp_c = '0;
        exp_v = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        repeat (2) begin
            step(1'b0, 32'h5, 32'h7);
            check64("after_rel_c", bus.C, 64'h0);
            check1("after_rel_valid", bus.out_valid, 1'b0);
        end

        // Reset landing between operand setup and the edge discards that operand.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = 32'h12345678;
        bus.B        = 32'h9ABCDEF0;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check64("inflight_c", bus.C, 64'h0);
        check1("inflight_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        step(1'b0, 32'h12345678, 32'h9ABCDEF0);
        check64("inflight_rel_c", bus.C, 64'h0);
        check1("inflight_rel_valid", bus.out_valid, 1'b0);

        // Randomized operands with toggling valid, biased now and then toward edge values.
        for (int i = 0; i < 10000; i++) begin
            rv = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 15))
                0: ra = 32'hFFFFFFFF;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h0;
                3: rb = 32'h0;
                default: ;
            endcase
            step(rv, ra, rb);
            check64("rand_c", bus.C, exp_c);
            check1("rand_valid", bus.out_valid, exp_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
